// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle between the datapath (master) and the serial comparator (slave).
// Operands are captured on an accepted start; results hold until the next done pulse.
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_great_B;
    logic             A_equal_B;
    logic             A_less_B;

    modport master (
        output start, A, B,
        input  busy, done, A_great_B, A_equal_B, A_less_B
    );

    modport slave (
        input  start, A, B,
        output busy, done, A_great_B, A_equal_B, A_less_B
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial N-bit magnitude compare, MSB first, through an external 1-bit comparator.
// Latency WIDTH cycles start->done; CMP_EARLY_EXIT_EN ends on the first differing bit.
// No backpressure: start is ignored while busy, and may be reissued in the done cycle.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_mag_comparator_if.slave ctrl,
    output logic                  a_bit,
    output logic                  b_bit,
    input  logic                  cmp_great,
    input  logic                  cmp_equal,
    input  logic                  cmp_less
);
    localparam int CNT_W = $clog2(WIDTH);

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        V_EQ,
        V_GT,
        V_LT
    } verdict_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    verdict_t         verdict_q, verdict_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       res_q, res_d;

    verdict_t         step_verdict;
    logic             step_decided;
    logic             finish;
    logic [2:0]       step_res;

    // Equality is implied when neither great nor less fires, so an all-zero
    // comparator response also counts as equal.
    logic unused_cmp_equal;
    assign unused_cmp_equal = cmp_equal;

    always_comb begin
        step_verdict = verdict_q;
        step_decided = decided_q;
        if (!decided_q) begin
            if (cmp_great) begin
                step_verdict = V_GT;
                step_decided = 1'b1;
            end else if (cmp_less) begin
                step_verdict = V_LT;
                step_decided = 1'b1;
            end
        end
    end

    always_comb begin
        finish = (cnt_q == '0) || (EARLY_EXIT && step_decided && !decided_q);
        case (step_verdict)
            V_GT:    step_res = 3'b100;
            V_LT:    step_res = 3'b001;
            default: step_res = 3'b010;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        verdict_d = verdict_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        res_d     = res_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl.start) begin
                    sh_a_d    = ctrl.A;
                    sh_b_d    = ctrl.B;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    decided_d = 1'b0;
                    verdict_d = V_EQ;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_a_d    = {sh_a_q[WIDTH-2:0], 1'b0};
                sh_b_d    = {sh_b_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                decided_d = step_decided;
                verdict_d = step_verdict;
                if (finish) begin
                    // Flush leftovers so the bit outputs read zero while idle.
                    sh_a_d  = '0;
                    sh_b_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    res_d   = step_res;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            verdict_q <= V_EQ;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            verdict_q <= verdict_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_q     <= res_d;
        end
    end

    assign a_bit          = sh_a_q[WIDTH-1];
    assign b_bit          = sh_b_q[WIDTH-1];
    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.A_great_B = res_q[2];
    assign ctrl.A_equal_B = res_q[1];
    assign ctrl.A_less_B  = res_q[0];
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboarded bench for serial_mag_comparator with a behavioural 1-bit comparator stage.
// Builds with or without CMP_EARLY_EXIT_EN; the reference latency follows the macro.
module tb_serial_mag_comparator;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a_bit, b_bit, cmp_great, cmp_equal, cmp_less;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   idle_from = 0;
    logic [2:0] exp_res = 3'b000;

    serial_mag_comparator_if #(.WIDTH(WIDTH)) ctrl ();

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (ctrl),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .cmp_great (cmp_great),
        .cmp_equal (cmp_equal),
        .cmp_less  (cmp_less)
    );

    // The 1-bit comparator used as the bit stage.
    assign cmp_great = a_bit & ~b_bit;
    assign cmp_equal = ~(a_bit ^ b_bit);
    assign cmp_less  = ~a_bit & b_bit;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               t0;
        int               done_cyc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       res;
    } txn_t;

    txn_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int first_diff = -1;
        for (int i = 0; i < WIDTH; i++)
            if (a[i] != b[i]) first_diff = i;
`ifdef CMP_EARLY_EXIT_EN
        if (first_diff >= 0) return WIDTH - first_diff;
`endif
        return WIDTH;
    endfunction

    function automatic logic [2:0] outs();
        return {ctrl.A_great_B, ctrl.A_equal_B, ctrl.A_less_B};
    endfunction

    // Monitor: pops the scoreboard on done and checks cycle-level behaviour.
    always @(negedge clk) begin
        if (rst_n) begin
            txn_t t;
            logic exp_busy, exp_a, exp_b;
            if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                fail_now("done_missing");
                void'(sb.pop_front());
            end
            if (ctrl.done) begin
                if (sb.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    t = sb.pop_front();
                    check("done_cycle", cyc, t.done_cyc);
                    check("result", {29'd0, outs()}, {29'd0, t.res});
                    exp_res = t.res;
                end
            end
            check("result_hold", {29'd0, outs()}, {29'd0, exp_res});
            exp_busy = 1'b0;
            exp_a    = 1'b0;
            exp_b    = 1'b0;
            if (sb.size() > 0 && cyc >= sb[0].t0 && cyc < sb[0].done_cyc) begin
                exp_busy = 1'b1;
                exp_a    = sb[0].a[WIDTH-1-(cyc-sb[0].t0)];
                exp_b    = sb[0].b[WIDTH-1-(cyc-sb[0].t0)];
            end
            check("busy", {31'd0, ctrl.busy}, {31'd0, exp_busy});
            check("a_bit", {31'd0, a_bit}, {31'd0, exp_a});
            check("b_bit", {31'd0, b_bit}, {31'd0, exp_b});
        end
    end

    // Caller is at a negedge; start is sampled at the next posedge (edge cyc+1).
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        txn_t t;
        int   lat;
        ctrl.A     = a;
        ctrl.B     = b;
        ctrl.start = 1'b1;
        t.t0 = cyc + 1;
        if (t.t0 >= idle_from) begin
            lat        = model_latency(a, b);
            t.done_cyc = t.t0 + lat;
            t.a        = a;
            t.b        = b;
            t.res      = {a > b, a == b, a < b};
            sb.push_back(t);
            idle_from  = t.done_cyc + 1;
        end
        @(negedge clk);
        ctrl.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done_cycle(input int budget);
        int n = 0;
        while (cyc + 1 < idle_from && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cyc + 1 != idle_from) fail_now("done_cycle_wait");
    endtask

    task automatic check_all_zero(input string name);
        check(name, {26'd0, ctrl.busy, ctrl.done, a_bit, b_bit, outs()}, 32'd0);
    endtask

    initial begin
        ctrl.start = 1'b0;
        ctrl.A     = '0;
        ctrl.B     = '0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'hA5, 8'hA5); drain(30);
        issue(8'h80, 8'h7F); drain(30);
        issue(8'h12, 8'h13); drain(30);

        // Start while busy is dropped; start in the done cycle is taken.
        issue(8'h3C, 8'h3B);
        @(negedge clk);
        issue(8'h00, 8'hFF);
        wait_done_cycle(30);
        issue(8'h55, 8'h56);
        drain(30);

        // Asynchronous reset in the middle of a compare.
        issue(8'h33, 8'h34);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #7 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_shift");
        sb.delete();
        exp_res   = 3'b000;
        idle_from = 0;
        @(negedge clk);
        check_all_zero("reset_mid_no_done");
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h01, 8'h00); drain(30);

        issue(8'h00, 8'hFF); drain(30);
        issue(8'hFF, 8'h00); drain(30);
        issue(8'h00, 8'h00); drain(30);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [WIDTH-1:0] ra, rb;
                ra = WIDTH'($urandom);
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ WIDTH'($urandom_range(1, 7));
                    default: rb = WIDTH'($urandom);
                endcase
                issue(ra, rb);
            end else begin
                @(negedge clk);
            end
        end
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
